// File: rtl/fpdiv_pkg.sv
// Shared types and constants for the Goldschmidt divider controller.
// Optional build macro: FPDIV_CTRL_REM_EN (adds the remainder-capture state).
package fpdiv_pkg;

    localparam int FPDIV_ITER_W = 4;

    // Multiplicand select (sel_mux4)
    localparam logic [1:0] SEL4_NUM_IA = 2'b00;
    localparam logic [1:0] SEL4_DEN_IA = 2'b01;
    localparam logic [1:0] SEL4_A_C    = 2'b10;
    localparam logic [1:0] SEL4_B_C    = 2'b11;

    // Factor select (sel_mux3)
    localparam logic [1:0] SEL3_IA  = 2'b00;
    localparam logic [1:0] SEL3_C   = 2'b01;
    localparam logic [1:0] SEL3_REM = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        IA_A,
        IA_B,
        IT_A,
        IT_B,
`ifdef FPDIV_CTRL_REM_EN
        REM,
`endif
        DONE
    } fpdiv_ctrl_state_t;

    // Datapath control word decoded from the state
    typedef struct packed {
        logic [1:0] sel_mux4;
        logic [1:0] sel_mux3;
        logic       en_a;
        logic       en_b;
        logic       en_rem;
    } fpdiv_ctrl_out_t;

endpackage

// File: rtl/fpdiv_ctrl_if.sv
// Control bundle between the sequencer (master) and the fpdiv datapath (slave).
interface fpdiv_ctrl_if;
    import fpdiv_pkg::*;

    logic                    start;
    logic                    busy;
    logic                    done;
    logic [1:0]              sel_mux4;
    logic [1:0]              sel_mux3;
    logic                    en_a;
    logic                    en_b;
    logic                    en_rem;
    logic [FPDIV_ITER_W-1:0] iter;

    modport master (
        input  start,
        output busy, done, sel_mux4, sel_mux3, en_a, en_b, en_rem, iter
    );

    modport slave (
        output start,
        input  busy, done, sel_mux4, sel_mux3, en_a, en_b, en_rem, iter
    );

endinterface

// File: rtl/fpdiv_iter_cnt.sv
// Pass counter: clear, increment, and terminal-count flag at ITERATIONS.
module fpdiv_iter_cnt
    import fpdiv_pkg::*;
#(
    parameter int unsigned ITERATIONS = 6
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clr,
    input  logic                    inc,
    output logic [FPDIV_ITER_W-1:0] iter,
    output logic                    last
);

    localparam logic [FPDIV_ITER_W-1:0] ITER_LAST = FPDIV_ITER_W'(ITERATIONS);

    // Pass number register; clear wins over increment.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: non-blocking so every register samples pre-edge values.
        if (!reset)
            iter <= '0;
        else if (clr)
            iter <= '0;
        else if (inc)
            iter <= iter + 1'b1;
    end

    assign last = (iter == ITER_LAST);

endmodule

// File: rtl/fpdiv_ctrl.sv
// Sequencer for the Goldschmidt divider: IA pass, refinement passes,
// optional remainder capture, then a one-cycle done pulse.
// Optional build macro: FPDIV_CTRL_REM_EN (REM state and en_rem).
module fpdiv_ctrl
    import fpdiv_pkg::*;
#(
    parameter int unsigned ITERATIONS = 6
) (
    input  logic         clk,
    input  logic         reset,
    fpdiv_ctrl_if.master bus
);

    // Selects shown during DONE: hold whatever the previous state drove.
`ifdef FPDIV_CTRL_REM_EN
    localparam logic [1:0] DONE_SEL4 = SEL4_A_C;
    localparam logic [1:0] DONE_SEL3 = SEL3_REM;
    localparam fpdiv_ctrl_state_t AFTER_LAST = REM;
`else
    localparam logic [1:0] DONE_SEL4 = (ITERATIONS == 1) ? SEL4_DEN_IA : SEL4_B_C;
    localparam logic [1:0] DONE_SEL3 = (ITERATIONS == 1) ? SEL3_IA : SEL3_C;
    localparam fpdiv_ctrl_state_t AFTER_LAST = DONE;
`endif

    fpdiv_ctrl_state_t state, next_state;
    fpdiv_ctrl_out_t   ctl;
    logic              cnt_clr;
    logic              cnt_inc;
    logic              last;

    fpdiv_iter_cnt #(
        .ITERATIONS(ITERATIONS)
    ) u_iter_cnt (
        .clk  (clk),
        .reset(reset),
        .clr  (cnt_clr),
        .inc  (cnt_inc),
        .iter (bus.iter),
        .last (last)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    // Next-state, counter control and Moore control-word decode.
    always_comb begin
        // NOTE: defaults first so no path through the case infers a latch.
        next_state = state;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        ctl        = '0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    next_state = IA_A;
                    cnt_inc    = 1'b1;
                end
            end
            IA_A: begin
                ctl.sel_mux4 = SEL4_NUM_IA;
                ctl.sel_mux3 = SEL3_IA;
                ctl.en_a     = 1'b1;
                next_state   = IA_B;
            end
            IA_B: begin
                ctl.sel_mux4 = SEL4_DEN_IA;
                ctl.sel_mux3 = SEL3_IA;
                ctl.en_b     = 1'b1;
                if (last) begin
                    next_state = AFTER_LAST;
                end else begin
                    next_state = IT_A;
                    cnt_inc    = 1'b1;
                end
            end
            IT_A: begin
                ctl.sel_mux4 = SEL4_A_C;
                ctl.sel_mux3 = SEL3_C;
                ctl.en_a     = 1'b1;
                next_state   = IT_B;
            end
            IT_B: begin
                ctl.sel_mux4 = SEL4_B_C;
                ctl.sel_mux3 = SEL3_C;
                ctl.en_b     = 1'b1;
                if (last) begin
                    next_state = AFTER_LAST;
                end else begin
                    next_state = IT_A;
                    cnt_inc    = 1'b1;
                end
            end
`ifdef FPDIV_CTRL_REM_EN
            REM: begin
                ctl.sel_mux4 = SEL4_A_C;
                ctl.sel_mux3 = SEL3_REM;
                ctl.en_rem   = 1'b1;
                next_state   = DONE;
            end
`endif
            DONE: begin
                ctl.sel_mux4 = DONE_SEL4;
                ctl.sel_mux3 = DONE_SEL3;
                next_state   = IDLE;
                cnt_clr      = 1'b1;
            end
            default: begin
                next_state = IDLE;
                cnt_clr    = 1'b1;
            end
        endcase
    end

    assign bus.busy     = (state != IDLE);
    assign bus.done     = (state == DONE);
    assign bus.sel_mux4 = ctl.sel_mux4;
    assign bus.sel_mux3 = ctl.sel_mux3;
    assign bus.en_a     = ctl.en_a;
    assign bus.en_b     = ctl.en_b;
`ifdef FPDIV_CTRL_REM_EN
    assign bus.en_rem   = ctl.en_rem;
`else
    assign bus.en_rem   = 1'b0;
`endif

endmodule

// File: tb/tb_fpdiv_ctrl.sv
// Self-checking bench: two controllers (ITERATIONS=6 and 1) against a
// position-in-sequence reference model, with random and directed start.
module tb_fpdiv_ctrl;
    import fpdiv_pkg::*;

`ifdef FPDIV_CTRL_REM_EN
    localparam bit REM_ON = 1'b1;
`else
    localparam bit REM_ON = 1'b0;
`endif

    typedef struct packed {
        logic       busy;
        logic       done;
        logic [1:0] s4;
        logic [1:0] s3;
        logic       ea;
        logic       eb;
        logic       er;
        logic [3:0] iter;
    } obs_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   pos6 = 0;
    int   pos1 = 0;

    always #5 clk = ~clk;

    fpdiv_ctrl_if bus6();
    fpdiv_ctrl_if bus1();
    assign bus6.start = start;
    assign bus1.start = start;

    fpdiv_ctrl #(.ITERATIONS(6)) dut6 (.clk(clk), .reset(reset), .bus(bus6.master));
    fpdiv_ctrl #(.ITERATIONS(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1.master));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycles from accept to the done cycle inclusive.
    function automatic int seq_len(input int n, input bit rem);
        return 2 * n + (rem ? 2 : 1);
    endfunction

    // Expected outputs at position pos (0 = idle, 1 = first cycle after accept).
    function automatic obs_t model_out(input int pos, input int n, input bit rem);
        obs_t o;
        int   pass;
        o = '0;
        if (pos == 0) return o;
        o.busy = 1'b1;
        if (pos <= 2 * n) begin
            pass   = (pos + 1) / 2;
            o.iter = pass[3:0];
            if (pos % 2 == 1) o.ea = 1'b1;
            else              o.eb = 1'b1;
            if (pass == 1) begin
                o.s4 = (pos % 2 == 1) ? 2'b00 : 2'b01;
                o.s3 = 2'b00;
            end else begin
                o.s4 = (pos % 2 == 1) ? 2'b10 : 2'b11;
                o.s3 = 2'b01;
            end
        end else if (rem && pos == 2 * n + 1) begin
            o.iter = 4'(n);
            o.s4   = 2'b10;
            o.s3   = 2'b10;
            o.er   = 1'b1;
        end else begin
            o.done = 1'b1;
            o.iter = 4'(n);
            if (rem)         begin o.s4 = 2'b10; o.s3 = 2'b10; end
            else if (n == 1) begin o.s4 = 2'b01; o.s3 = 2'b00; end
            else             begin o.s4 = 2'b11; o.s3 = 2'b01; end
        end
        return o;
    endfunction

    function automatic int model_next(input int pos, input int n, input bit st);
        if (pos == 0) return st ? 1 : 0;
        if (pos == seq_len(n, REM_ON)) return 0;
        return pos + 1;
    endfunction

    // Reference model position tracking.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            pos6 <= 0;
            pos1 <= 0;
        end else begin
            pos6 <= model_next(pos6, 6, start);
            pos1 <= model_next(pos1, 1, start);
        end
    end

    // Per-cycle compare against the model, plus enable exclusivity.
    always @(posedge clk) begin
        obs_t a6, a1;
        #2;
        a6 = {bus6.busy, bus6.done, bus6.sel_mux4, bus6.sel_mux3,
              bus6.en_a, bus6.en_b, bus6.en_rem, bus6.iter};
        a1 = {bus1.busy, bus1.done, bus1.sel_mux4, bus1.sel_mux3,
              bus1.en_a, bus1.en_b, bus1.en_rem, bus1.iter};
        check("cyc_n6", 32'(a6), 32'(model_out(pos6, 6, REM_ON)));
        check("cyc_n1", 32'(a1), 32'(model_out(pos1, 1, REM_ON)));
        check("excl_n6", 32'($countones({bus6.en_a, bus6.en_b, bus6.en_rem}) <= 1), 32'd1);
        check("excl_n1", 32'($countones({bus1.en_a, bus1.en_b, bus1.en_rem}) <= 1), 32'd1);
    end

    // One start pulse from idle; measure cycles to done on both instances.
    task automatic single_run();
        int lat6, lat1;
        lat6 = -1;
        lat1 = -1;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int k = 2; k <= 40; k++) begin
            @(posedge clk);
            #2;
            if (bus6.done && lat6 < 0) lat6 = k;
            if (bus1.done && lat1 < 0) lat1 = k;
        end
        check("latency_n6", 32'(lat6), REM_ON ? 32'd14 : 32'd13);
        check("latency_n1", 32'(lat1), REM_ON ? 32'd4 : 32'd3);
    endtask

    initial begin
        // Hand-computed pins on the model itself.
        check("pin_ia_a",  32'(model_out(1, 6, 1'b1)),  32'(13'b1_0_00_00_1_0_0_0001));
        check("pin_itb6",  32'(model_out(12, 6, 1'b1)), 32'(13'b1_0_11_01_0_1_0_0110));
        check("pin_done",  32'(model_out(14, 6, 1'b1)), 32'(13'b1_1_10_10_0_0_0_0110));
        check("pin_done0", 32'(model_out(13, 6, 1'b0)), 32'(13'b1_1_11_01_0_0_0_0110));
        check("pin_len",   32'(seq_len(1, 1'b0)), 32'd3);

        // Reset for two cycles, then release with start low.
        repeat (2) @(negedge clk);
        check("reset_state", 32'({bus6.busy, bus6.done, bus6.sel_mux4, bus6.sel_mux3,
              bus6.en_a, bus6.en_b, bus6.en_rem, bus6.iter}), 32'd0);
        reset = 1'b1;
        repeat (6) @(negedge clk);

        // Single pulse with latency check (the first sampled cycle is t+2).
        single_run();

        // Start held high: back-to-back runs separated by one idle cycle.
        @(negedge clk) start = 1'b1;
        repeat (60) @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);

        // Random start traffic.
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            start = ($urandom_range(0, 3) == 0);
        end
        start = 1'b0;
        repeat (20) @(negedge clk);

        // Reset dropped during IT_B of pass 3.
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        begin
            bit hit;
            hit = 1'b0;
            for (int k = 0; k < 40; k++) begin
                @(posedge clk);
                #1;
                if (pos6 == 6) begin
                    hit = 1'b1;
                    break;
                end
            end
            check("reach_itb3", 32'(hit), 32'd1);
        end
        #2;
        check("itb3_en_b", 32'(bus6.en_b), 32'd1);
        reset = 1'b0;
        #1;
        check("async_en", 32'({bus6.en_a, bus6.en_b, bus6.en_rem}), 32'd0);
        check("async_busy", 32'({bus6.busy, bus6.done, bus6.iter}), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        single_run();
        repeat (5) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fpdiv_ctrl.md
# fpdiv_ctrl

Sequencing controller for the Goldschmidt floating-point divider datapath (`fpdiv`). It accepts a start request and drives the divider's mux selects and register enables (`sel_mux4`, `sel_mux3`, `en_a`, `en_b`, `en_rem`) through the initial-approximation pass, the refinement iterations and the final remainder capture. It then signals completion. It sits directly upstream of `fpdiv` and replaces hand-driven control sequences.

## Interface
- `ITERATIONS`, default 6: total Goldschmidt passes, including the initial-approximation pass; legal range 1..15.
- `clk`  in  1  clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a division; sampled only in IDLE.
- `busy`  out  1  high from the first cycle after an accepted start until DONE is exited.
- `done`  out  1  one-cycle pulse; quotient/remainder registers in `fpdiv` are valid.
- `sel_mux4`  out  2  multiplicand select: 00 = numerator×IA, 01 = denominator×IA, 10 = reg A×C, 11 = reg B×C.
- `sel_mux3`  out  2  factor select: 00 = IA table, 01 = reg C (2−B), 10 = remainder path.
- `en_a`  out  1  load enable for `fpdiv` register A (numerator path).
- `en_b`  out  1  load enable for `fpdiv` register B (denominator path).
- `en_rem`  out  1  load enable for the remainder register.
- `iter`  out  4  current pass number, 0 in IDLE, 1..ITERATIONS while iterating.

## Operation
- States: IDLE, IA_A, IA_B, IT_A, IT_B, REM, DONE.
- Outputs are Moore-decoded from the state register and `iter`; there are no combinational paths from `start`.
- IDLE: every output is 0, including all selects and enables. If `start`=1, go to IA_A and set `iter`=1.
- IA_A: `sel_mux4`=00, `sel_mux3`=00, `en_a`=1. Next state is IA_B.
- IA_B: `sel_mux4`=01, `sel_mux3`=00, `en_b`=1.
  - If `iter`==ITERATIONS, go to REM.
  - Otherwise increment `iter` and go to IT_A.
- IT_A: `sel_mux4`=10, `sel_mux3`=01, `en_a`=1. Next state is IT_B.
- IT_B: `sel_mux4`=11, `sel_mux3`=01, `en_b`=1.
  - If `iter`==ITERATIONS, go to REM.
  - Otherwise increment `iter` and go to IT_A.
- REM: `sel_mux4`=10, `sel_mux3`=10, `en_rem`=1, `en_a`=`en_b`=0. Next state is DONE.
- DONE: `done`=1 and `busy`=1; selects hold the REM values with all enables 0. Next state is IDLE and `iter` clears to 0.
- `busy`=1 in every state except IDLE.
- Enable exclusivity: at most one of `en_a`, `en_b`, `en_rem` is high in any cycle.
- `start` outside IDLE is ignored; this includes the DONE cycle, so no back-to-back restart is possible.
- A new start is accepted in the IDLE cycle after DONE.

## Timing
- Reset values: state IDLE, `iter`=0; `busy`, `done`, `en_a`, `en_b`, `en_rem` = 0; `sel_mux4`=`sel_mux3`=00.
- Reset asserted mid-sequence forces IDLE immediately, asynchronously, and all enables drop in the same instant. After deassertion the controller waits for a new `start`.
- Start accepted at edge t:
  - IA_A during cycle t+1.
  - Each pass occupies 2 cycles, so the last IT_B is cycle t+2·ITERATIONS.
  - REM is cycle t+2·ITERATIONS+1.
  - `done` is high during cycle t+2·ITERATIONS+2.
- With ITERATIONS=6: 12 pass cycles, REM at t+13, `done` at t+14.
- ITERATIONS=1: IA_B transitions straight to REM.

## Configuration
- Macro: `FPDIV_CTRL_REM_EN`.
- Defined: REM state present, behaving as above.
- Undefined:
  - REM is not compiled; the final IA_B/IT_B goes directly to DONE.
  - `en_rem` is tied to 0.
  - `done` arrives at t+2·ITERATIONS+1 (t+13 for the default).
  - In DONE the selects hold the final IT_B (or IA_B) values with all enables 0.

## Structure
- Shared package `fpdiv_pkg` holds:
  - The state enum typedef `fpdiv_ctrl_state_t`.
  - The select constants: `SEL4_NUM_IA`, `SEL4_DEN_IA`, `SEL4_A_C`, `SEL4_B_C`, `SEL3_IA`, `SEL3_C`, `SEL3_REM`.
  - `FPDIV_ITER_W`=4.
- One sub-module is natural: `fpdiv_iter_cnt`.
  - Clear, increment and terminal-count compare against ITERATIONS.
  - Same clock and reset as the parent.

## Test plan
- Reset low for 2 cycles, then high with `start`=0: all outputs 0 and `iter`=0 indefinitely.
- `start` pulse, ITERATIONS=6, macro defined:
  - Cycles t+1..t+12 show `sel_mux4` sequence 00,01,10,11,10,11,…, with `sel_mux3` 00,00 then 01.
  - `en_a` and `en_b` alternate, starting with `en_a`.
  - `en_rem`=1 only at t+13.
  - `done`=1 only at t+14.
  - `iter` steps 1..6.
- `start` held high continuously: sequences repeat with exactly one IDLE cycle between DONE and the next IA_A. No start is accepted during busy or DONE.
- Reset dropped during IT_B of pass 3: all enables go to 0 immediately and state is IDLE. After release, a new `start` yields a full correct 14-cycle sequence.
- ITERATIONS=1, macro undefined: IA_A at t+1, IA_B at t+2, `done` at t+3, `en_rem` never asserted.
- Every test: assert enable exclusivity and that `busy` equals (state ≠ IDLE) in every cycle.
